// File: rtl/mem_checker_pkg.sv
// Shared types and constants for the memory-checker operation sequencer.
package mem_checker_pkg;

  typedef enum logic [1:0] {
    WRITE_ONLY = 2'd0,
    READ_ONLY  = 2'd1,
    WRITE_READ = 2'd2
  } test_mode_e;

  typedef enum logic {
    ADDR_SEQ  = 1'b0,
    ADDR_RAND = 1'b1
  } addr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/mem_test_addr_gen.sv
// Word-address generator: sequential stride or 16-bit LFSR, loaded at start
// and stepped once per completed address step.
module mem_test_addr_gen
  import mem_checker_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 11
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               advance_i,
  input  addr_mode_e         mode_i,
  input  logic [ADDR_W-1:0]  base_i,
  input  logic [15:0]        seed_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [ADDR_W-1:0]  addr_o
);

  addr_mode_e         mode_q;
  logic [BURST_W-1:0] burst_q;
  logic [15:0]        lfsr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        seed_eff;
  logic [15:0]        lfsr_nxt;

  assign seed_eff = (seed_i == 16'h0000) ? LFSR_DEFAULT_SEED : seed_i;
  assign lfsr_nxt = lfsr_next(lfsr_q);
  assign addr_o   = addr_q;

  // Latch the generator configuration on load, then step on each advance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q  <= ADDR_SEQ;
      burst_q <= '0;
      lfsr_q  <= '0;
      addr_q  <= '0;
    end else if (load_i) begin
      mode_q  <= mode_i;
      burst_q <= burst_i;
      lfsr_q  <= seed_eff;
      addr_q  <= (mode_i == ADDR_RAND) ? ADDR_W'(seed_eff) : base_i;
    end else if (advance_i) begin
      if (mode_q == ADDR_RAND) begin
        lfsr_q <= lfsr_nxt;
        addr_q <= ADDR_W'(lfsr_nxt);
      end else begin
        addr_q <= ADDR_W'(addr_q + burst_q);
      end
    end else begin
      addr_q <= addr_q;
    end
  end

endmodule

// File: rtl/mem_test_sequencer.sv
// Produces the write/read operation stream for the memory-checker transmitter
// and reports completion once every issued read burst has been returned.
module mem_test_sequencer
  import mem_checker_pkg::*;
#(
  parameter int AMM_ADDR_W    = 12,
  parameter int AMM_BURST_W   = 11,
  parameter int BYTE_PER_WORD = 16,
  parameter int ADDR_W        = AMM_ADDR_W - $clog2(BYTE_PER_WORD),
  parameter int CNT_W         = 32,
  parameter int OUTST_W       = AMM_BURST_W + 4
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic [1:0]                         test_mode_i,
  input  logic                               addr_mode_i,
  input  logic [ADDR_W-1:0]                  base_addr_i,
  input  logic [15:0]                        seed_i,
  input  logic [CNT_W-1:0]                   trans_count_i,
  input  logic [AMM_BURST_W-1:0]             burst_count_i,
  input  logic [$clog2(BYTE_PER_WORD)-1:0]   start_offset_i,
  input  logic [$clog2(BYTE_PER_WORD):0]     end_offset_i,
  input  logic                               tx_busy_i,
  input  logic                               readdatavalid_i,
  output logic                               op_valid_o,
  output logic                               op_type_o,
  output logic [ADDR_W-1:0]                  op_address_o,
  output logic [AMM_BURST_W-1:0]             op_burst_count_o,
  output logic [$clog2(BYTE_PER_WORD)-1:0]   op_start_offset_o,
  output logic [$clog2(BYTE_PER_WORD):0]     op_end_offset_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               aborted_o,
  output logic                               protocol_err_o,
  output logic [CNT_W-1:0]                   steps_done_o
);

  localparam int OFF_W = $clog2(BYTE_PER_WORD);
  localparam logic [OFF_W:0] EOFF_FULL = (OFF_W + 1)'(BYTE_PER_WORD);

  seq_state_e             state_q;
  test_mode_e             mode_q;
  logic [AMM_BURST_W-1:0] burst_q;
  logic [OFF_W-1:0]       soff_q, op_soff_q;
  logic [OFF_W:0]         eoff_q, op_eoff_q;
  logic [CNT_W-1:0]       trans_q, steps_q;
  logic [OUTST_W-1:0]     outst_q, outst_d;
  logic                   op_valid_q, op_type_q, busy_q, done_q;
  logic                   aborted_q, abort_seen_q, perr_q;

  test_mode_e             mode_in;
  logic [AMM_BURST_W-1:0] burst_eff;
  logic                   accept, step_done, last_step, issue_stop, nxt_read, start_go;

  assign mode_in    = (test_mode_i == 2'd3) ? WRITE_ONLY : test_mode_e'(test_mode_i);
  assign burst_eff  = (burst_count_i == '0) ? AMM_BURST_W'(1'b1) : burst_count_i;
  assign start_go   = (state_q == ST_IDLE) && start_i;
  assign accept     = op_valid_q && !tx_busy_i;
  // In write-then-read mode only the read accept closes a step.
  assign step_done  = accept && (op_type_q || (mode_q != WRITE_READ));
  assign last_step  = (steps_q + CNT_W'(1'b1)) == trans_q;
  assign issue_stop = abort_i || (step_done && last_step);
  assign nxt_read   = step_done ? (mode_q == READ_ONLY) : 1'b1;

  // Outstanding read words: add a burst per read accept, retire one per beat.
  always_comb begin
    outst_d = outst_q;
    if (accept && op_type_q) begin
      outst_d = outst_d + OUTST_W'(burst_q);
    end else begin
      outst_d = outst_d;
    end
    if (readdatavalid_i && (outst_q != '0)) begin
      outst_d = outst_d - OUTST_W'(1'b1);
    end else begin
      outst_d = outst_d;
    end
  end

  mem_test_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BURST_W (AMM_BURST_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .load_i    (start_go),
    .advance_i (step_done),
    .mode_i    (addr_mode_e'(addr_mode_i)),
    .base_i    (base_addr_i),
    .seed_i    (seed_i),
    .burst_i   (burst_eff),
    .addr_o    (op_address_o)
  );

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= WRITE_ONLY;
      burst_q      <= '0;
      soff_q       <= '0;
      eoff_q       <= '0;
      op_soff_q    <= '0;
      op_eoff_q    <= '0;
      trans_q      <= '0;
      steps_q      <= '0;
      outst_q      <= '0;
      op_valid_q   <= 1'b0;
      op_type_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_seen_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (readdatavalid_i && (outst_q == '0)) begin
        perr_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            mode_q       <= mode_in;
            burst_q      <= burst_eff;
            soff_q       <= start_offset_i;
            eoff_q       <= end_offset_i;
            trans_q      <= trans_count_i;
            steps_q      <= '0;
            busy_q       <= 1'b1;
            aborted_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            perr_q       <= 1'b0;
            op_type_q    <= (mode_in == READ_ONLY);
            op_soff_q    <= (mode_in == READ_ONLY) ? '0 : start_offset_i;
            op_eoff_q    <= (mode_in == READ_ONLY) ? EOFF_FULL : end_offset_i;
            op_valid_q   <= (trans_count_i != '0);
            state_q      <= (trans_count_i == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort_i) begin
            abort_seen_q <= 1'b1;
          end
          if (step_done) begin
            steps_q <= steps_q + CNT_W'(1'b1);
          end
          if (issue_stop) begin
            op_valid_q <= 1'b0;
            // Nothing left to drain: finish without passing through DRAIN.
            if (outst_d == '0) begin
              state_q   <= ST_FINISH;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              aborted_q <= abort_seen_q | abort_i;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (accept) begin
            op_type_q <= nxt_read;
            op_soff_q <= nxt_read ? '0 : soff_q;
            op_eoff_q <= nxt_read ? EOFF_FULL : eoff_q;
          end
        end
        ST_DRAIN: begin
          if (abort_i) begin
            abort_seen_q <= 1'b1;
          end
          if (outst_q == '0) begin
            state_q   <= ST_FINISH;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            aborted_q <= abort_seen_q | abort_i;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_valid_o        = op_valid_q;
  assign op_type_o         = op_type_q;
  assign op_burst_count_o  = burst_q;
  assign op_start_offset_o = op_soff_q;
  assign op_end_offset_o   = op_eoff_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign aborted_o         = aborted_q;
  assign protocol_err_o    = perr_q;
  assign steps_done_o      = steps_q;

endmodule
